// File: rtl/frame_fetch_scheduler_pkg.sv
// Shared constants and types for the frame fetch scheduler and the port-B memory stage.
// Region bases are in port-B address units; one pixel per address.
package frame_fetch_scheduler_pkg;

  localparam int IMG_PIXELS = 90000;
  localparam int RD_LATENCY = 2;
  localparam int FIFO_DEPTH = 8;
  localparam int ADDR_W     = 18;
  localparam int DATA_W     = 24;
  localparam int CNT_W      = 17;

  localparam logic [ADDR_W-1:0] IMAGE_ROM_BASE = 18'd0;
  localparam logic [ADDR_W-1:0] SIN_ROM_BASE   = 18'd90000;
  localparam logic [ADDR_W-1:0] RAM_BASE       = 18'd90300;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

  function automatic logic [ADDR_W-1:0] region_base(input logic src_sel);
    return src_sel ? RAM_BASE : IMAGE_ROM_BASE;
  endfunction

endpackage

// File: rtl/frame_fetch_scheduler_if.sv
// Port-B read bus plus the pixel valid/ready stream, bundled for the scheduler.
// master = scheduler side, slave = memory/consumer side.
interface frame_fetch_scheduler_if;
  import frame_fetch_scheduler_pkg::*;

  logic [ADDR_W-1:0] address_b;
  logic [DATA_W-1:0] read_data_b;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_last;

  modport master (
    output address_b, pix_data, pix_valid, pix_last,
    input  read_data_b, pix_ready
  );

  modport slave (
    input  address_b, pix_data, pix_valid, pix_last,
    output read_data_b, pix_ready
  );
endinterface

// File: rtl/frame_fetch_scheduler_pixel_fifo.sv
// Synchronous pixel FIFO with registered storage and a flush that wins over push/pop.
// Overflow protection is the caller's job (credit-based issue).
module pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && !empty && !flush;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/frame_fetch_scheduler.sv
// Streams one frame from port B (ROM or RAM region) into a pixel FIFO under credit control.
//   state | meaning
//   IDLE  | waiting for start, nothing in flight
//   FETCH | issuing one read per clock while credits remain
//   DRAIN | all reads issued, waiting for the last pixel to be accepted
//   DONE  | frame complete, waiting for the next start
module frame_fetch_scheduler
  import frame_fetch_scheduler_pkg::*;
#(
  parameter int FRAME_PIXELS = IMG_PIXELS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    src_sel,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  frame_fetch_scheduler_if.master bus
);
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

  fetch_state_e          state_q, state_d;
  logic [ADDR_W-1:0]     base_q, base_d, addr_q, addr_d;
  logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d, out_cnt_q, out_cnt_d;
  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic                  done_q, done_d;
  logic [FCNT_W-1:0]     fifo_count, inflight;
  logic                  fifo_empty, fifo_full;
  logic [DATA_W-1:0]     fifo_head;
  logic                  issue, push, accept;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + FCNT_W'(pipe_q[i]);
  end

  // Credits count both buffered and in-flight pixels, so a push can never find the FIFO full.
  assign issue  = (state_q == ST_FETCH) && !abort &&
                  ((fifo_count + inflight) < FCNT_W'(FIFO_DEPTH));
  assign push   = pipe_q[RD_LATENCY-1] && !abort;
  assign accept = !fifo_empty && bus.pix_ready;

  assign bus.address_b = addr_q;
  assign bus.pix_data  = fifo_head;
  assign bus.pix_valid = !fifo_empty;
  assign bus.pix_last  = !fifo_empty && (out_cnt_q == LAST_IDX);
  assign busy          = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign done          = done_q;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = accept ? out_cnt_q + CNT_W'(1) : out_cnt_q;
    pipe_d      = {pipe_q[RD_LATENCY-2:0], issue};
    done_d      = 1'b0;
    if (issue) begin
      addr_d      = base_q + ADDR_W'(issue_cnt_q);
      issue_cnt_d = issue_cnt_q + CNT_W'(1);
    end
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          base_d      = region_base(src_sel);
          issue_cnt_d = '0;
          out_cnt_d   = '0;
          state_d     = ST_FETCH;
        end
      end
      ST_FETCH: if (issue && issue_cnt_q == LAST_IDX) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (accept && out_cnt_q == LAST_IDX) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      pipe_d  = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      pipe_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      pipe_q      <= pipe_d;
      done_q      <= done_d;
    end
  end

  pixel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.read_data_b),
    .pop       (accept),
    .flush     (abort),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && fifo_full && !accept));
endmodule

// File: tb/tb_frame_fetch_scheduler.sv
// Directed bench for frame_fetch_scheduler with a reduced frame size and a data=address memory.
// Expected pixels are queued at start and checked on every accepted pixel.
module tb_frame_fetch_scheduler;
  import frame_fetch_scheduler_pkg::*;

  localparam int N = 40;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic src_sel = 1'b0;
  logic abort = 1'b0;
  logic busy, done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  exp_t exp_q[$];

  frame_fetch_scheduler_if bus();

  frame_fetch_scheduler #(.FRAME_PIXELS(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .src_sel (src_sel),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // address_b is already registered inside the scheduler; this flop is the data-out register.
  always @(posedge clk) bus.read_data_b <= DATA_W'(bus.address_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input logic [ADDR_W-1:0] base);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.data = DATA_W'(base) + DATA_W'(i);
      e.last = (i == N - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic sel);
    src_sel = sel;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rand_ready);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      if (rand_ready) bus.pix_ready = ($urandom_range(0, 99) < 30);
      tick();
      n++;
    end
    bus.pix_ready = 1'b1;
    check("done_seen", 32'(done_cnt != d0), 32'd1);
    repeat (3) tick();
    check("done_once", 32'(done_cnt - d0), 32'd1);
    check("busy_low", 32'(busy), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},  32'(bus.address_b), 32'd0);
    check({tag, "_valid"}, 32'(bus.pix_valid), 32'd0);
    check({tag, "_last"},  32'(bus.pix_last),  32'd0);
    check({tag, "_busy"},  32'(busy),          32'd0);
    check({tag, "_done"},  32'(done),          32'd0);
    check({tag, "_data"},  32'(bus.pix_data),  32'd0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (done) done_cnt++;
      if (bus.pix_valid && bus.pix_ready) begin
        exp_t e;
        acc_cnt++;
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("pix_data", 32'(bus.pix_data), 32'(e.data));
          check("pix_last", 32'(bus.pix_last), 32'(e.last));
        end
      end
    end
  end

  initial begin
    int a0;
    int d0;
    int n;
    bus.pix_ready = 1'b0;

    #3;
    check_reset_outputs("reset");
    tick();
    rst = 1'b1;
    tick();

    // ROM frame, ready always high: first pixel three clocks after start.
    bus.pix_ready = 1'b1;
    load_frame(IMAGE_ROM_BASE);
    pulse_start(1'b0);
    check("busy_after_start", 32'(busy), 32'd1);
    tick();
    tick();
    check("lat_not_early", 32'(bus.pix_valid), 32'd0);
    tick();
    check("lat_first_valid", 32'(bus.pix_valid), 32'd1);
    check("lat_first_data", 32'(bus.pix_data), 32'd0);
    wait_done(2000, 1'b0);
    check("rom_last_addr", 32'(bus.address_b), 32'(N - 1));

    // RAM frame.
    load_frame(RAM_BASE);
    pulse_start(1'b1);
    wait_done(2000, 1'b0);
    check("ram_last_addr", 32'(bus.address_b), 32'(RAM_BASE) + 32'(N - 1));

    // Consumer stalled: issue stops after exactly FIFO_DEPTH reads.
    bus.pix_ready = 1'b0;
    load_frame(IMAGE_ROM_BASE);
    pulse_start(1'b0);
    repeat (50) tick();
    check("stall_addr", 32'(bus.address_b), 32'(FIFO_DEPTH - 1));
    check("stall_valid", 32'(bus.pix_valid), 32'd1);
    check("stall_head", 32'(bus.pix_data), 32'd0);
    check("stall_busy", 32'(busy), 32'd1);
    bus.pix_ready = 1'b1;
    wait_done(2000, 1'b0);

    // Random back-pressure.
    load_frame(IMAGE_ROM_BASE);
    pulse_start(1'b0);
    wait_done(3000, 1'b1);

    // start while busy must not restart or change the source.
    load_frame(IMAGE_ROM_BASE);
    pulse_start(1'b0);
    repeat (10) tick();
    pulse_start(1'b1);
    src_sel = 1'b0;
    wait_done(2000, 1'b0);
    check("busy_start_addr", 32'(bus.address_b), 32'(N - 1));

    // Abort mid-stream with reads in flight.
    load_frame(IMAGE_ROM_BASE);
    a0 = acc_cnt;
    pulse_start(1'b0);
    n = 0;
    while ((acc_cnt - a0) < 20 && n < 500) begin
      tick();
      n++;
    end
    check("abort_reached", 32'((acc_cnt - a0) >= 20), 32'd1);
    bus.pix_ready = 1'b0;
    abort = 1'b1;
    d0 = done_cnt;
    tick();
    abort = 1'b0;
    exp_q.delete();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(bus.pix_valid), 32'd0);
    repeat (4) begin
      tick();
      check("abort_no_stale", 32'(bus.pix_valid), 32'd0);
    end
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);

    bus.pix_ready = 1'b1;
    load_frame(IMAGE_ROM_BASE);
    pulse_start(1'b0);
    wait_done(2000, 1'b0);

    // Asynchronous reset in the middle of FETCH.
    load_frame(RAM_BASE);
    pulse_start(1'b1);
    repeat (10) tick();
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    exp_q.delete();
    tick();
    rst = 1'b1;
    tick();

    load_frame(RAM_BASE);
    pulse_start(1'b1);
    wait_done(2000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_fetch_scheduler.md
Name: frame_fetch_scheduler

Overview:
Sequences memory port B (read-only, registered address in, registered data out) to stream one 300x300 frame of 24-bit pixels to a display/consumer. The source is either the image ROM region (base 0) or the processed-image RAM region (base 90300). Reads are issued one per clock under credit control, so the FIFO can never overflow. Return data is buffered in a small FIFO and presented on a valid/ready interface with a last-pixel flag.

Parameters:
IMG_PIXELS, 90000, pixels per frame (300x300)
RD_LATENCY, 2, clocks from address_b driven to read_data_b valid (input and output registers)
FIFO_DEPTH, 8, pixel buffer entries; power of two, must be >= RD_LATENCY+1
ADDR_W, 18, port-B address width
DATA_W, 24, pixel width

Ports:
clk  in  1  single system clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a frame when IDLE or DONE
src_sel  in  1  0 = image ROM region (base 0), 1 = RAM region (base 90300); sampled on accepted start
abort  in  1  drops the current frame
address_b  out  ADDR_W  port-B read address
read_data_b  in  DATA_W  port-B read data
pix_data  out  DATA_W  FIFO head pixel
pix_valid  out  1  FIFO non-empty
pix_ready  in  1  consumer accepts when pix_valid && pix_ready
pix_last  out  1  head pixel is frame index IMG_PIXELS-1
busy  out  1  high in FETCH or DRAIN
done  out  1  one-cycle pulse when the last pixel is accepted

Behaviour:
- Reset (rst low, async): state=IDLE; address_b=0; pix_valid=0; pix_last=0; busy=0; done=0; pixel counters=0; in-flight pipe cleared; FIFO emptied. pix_data is don't-care while pix_valid=0 and is 0 after reset.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE/DONE + start: latch base (0 or 90300), issue_cnt=0, out_cnt=0, go to FETCH. DONE without start holds DONE; busy=0.
- FETCH: a read is issued in a cycle when fifo_count + inflight < FIFO_DEPTH.
  - On issue: address_b = base + issue_cnt, registered; issue_cnt increments.
  - When issue_cnt reaches IMG_PIXELS-1 and is issued: go to DRAIN.
  - address_b holds its last value when no read is issued.
- In-flight tracking: RD_LATENCY-deep valid shift register; bit 0 is set on issue.
  - When the tail bit is set, read_data_b is written to the FIFO in that cycle.
  - inflight = popcount of the shift register.
- DRAIN: no new reads. Leave DRAIN when out_cnt reaches IMG_PIXELS, i.e. the pixel with pix_last=1 is accepted. Then pulse done for one cycle and go to DONE.
- Consumer side:
  - out_cnt increments on each accept.
  - pix_last = pix_valid && (out_cnt == IMG_PIXELS-1).
  - FIFO push and pop in the same cycle are legal; count is unchanged.
  - The credit rule guarantees no push when full. An overflow is an assertion failure.
- Stalls: pix_ready held low lets FETCH issue until credits hit 0 (FIFO_DEPTH pixels buffered/in flight). Issue then stops with no data loss.
- start while busy: ignored.
- abort in any state (priority over start):
  - Next state IDLE; FIFO flushed; shift register cleared.
  - Returning in-flight data is discarded; done is not pulsed.
- Widths: base + issue_cnt computed in ADDR_W bits. The maximum 90300+89999=180299 fits 18 bits. issue_cnt and out_cnt are 17 bits.
- Throughput: with pix_ready=1 constantly, one pixel per clock after an initial latency of RD_LATENCY+1 clocks from start to first pix_valid.

Decomposition:
- Shared package: constants IMAGE_ROM_BASE=0, SIN_ROM_BASE=90000, RAM_BASE=90300, IMG_PIXELS=90000, DATA_W=24, ADDR_W=18; enum for the fetch state.
- The memory stage decode uses the same region constants from this package.
- One sub-module: pixel_fifo, a synchronous FIFO (DEPTH, WIDTH) with push/pop/count/empty/full, async active-low reset.

Test Plan:
- Model port B with a behavioural 2-cycle memory returning data=address. src_sel=0, pix_ready=1, start pulse -> first pix_valid 3 clocks later with pix_data=0. Then one pixel per clock, 0..89999; pix_last only on 89999; done pulses once; busy falls.
- src_sel=1, pix_ready=1 -> address_b sweeps 90300..180299; first pix_data=90300, last=180299.
- pix_ready=0 for 50 cycles after start -> exactly 8 reads issued, pix_valid=1. pix_ready=1 then restores an in-order stream with no gap or duplicate (checked against scoreboard).
- Random pix_ready at 30% -> all 90000 pixels received in order; FIFO-full assertion never fires; done exactly once.
- abort at pixel 1000 with 2 reads in flight -> IDLE next cycle; pix_valid=0; stale data not pushed. A new start then begins again at base.
- rst asserted mid-FETCH -> all outputs return to reset values immediately (async). start pulsed during busy -> ignored, stream unaffected.
